// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops one TX word per frame, drives SCK/NSS/MOSI,
// samples MISO and hands the received word to the RX FIFO.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 16,
    parameter int NSS_NUM    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic                  ass_i,
    input  logic [1:0]            dtb_i,
    input  logic [NSS_NUM-1:0]    nss_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  spi_sck_o,
    output logic [NSS_NUM-1:0]    spi_nss_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [6:0]            edge_q, edge_d;
    logic [DATA_WIDTH-1:0] word_q, word_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, ass_q, ass_d;
    logic [1:0]            dtb_q, dtb_d;
    logic [NSS_NUM-1:0]    nss_l_q, nss_l_d, nss_q, nss_d;
    logic                  sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, rx_valid_q, rx_valid_d;

    logic                  wrap, do_edge;
    logic [DIV_WIDTH-1:0]  cnt_next;
    logic [6:0]            n_bits, two_n, e, tx_idx, rx_idx, tx_pos, rx_pos, n_in, fpos;

    function automatic logic [6:0] frame_bits(input logic [1:0] dtb);
        logic [2:0] d1;
        d1 = {1'b0, dtb} + 3'd1;
        return {1'b0, d1, 3'b000};
    endfunction

    function automatic logic [6:0] bit_pos(input logic [6:0] idx, input logic [6:0] n,
                                           input logic lsb);
        return lsb ? idx : (n - 7'd1 - idx);
    endfunction

    assign tx_ready_o = rst_n_i & (state_q == S_IDLE) & en_i & tx_valid_i &
                        (~rx_valid_q | rx_ready_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        word_d     = word_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        ass_d      = ass_q;
        dtb_d      = dtb_q;
        nss_l_d    = nss_l_q;
        div_d      = div_q;
        sck_d      = sck_q;
        nss_d      = nss_q;
        mosi_d     = mosi_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready_i;
        do_edge    = 1'b0;

        wrap     = (cnt_q == div_q);
        cnt_next = wrap ? '0 : cnt_q + 1'b1;
        n_bits   = frame_bits(dtb_q);
        two_n    = {n_bits[5:0], 1'b0};
        e        = edge_q + 7'd1;
        // Bit indices derive from the edge number: each bit spans one leading+trailing pair.
        tx_idx   = cpha_q ? ((e - 7'd1) >> 1) : (e >> 1);
        rx_idx   = cpha_q ? ((e >> 1) - 7'd1) : ((e - 7'd1) >> 1);
        tx_pos   = bit_pos(tx_idx, n_bits, lsb_q);
        rx_pos   = bit_pos(rx_idx, n_bits, lsb_q);
        n_in     = frame_bits(dtb_i);
        fpos     = lsb_i ? 7'd0 : (n_in - 7'd1);

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                edge_d = '0;
                sck_d  = cpol_i;
                nss_d  = ass_i ? '1 : ~nss_i;
                mosi_d = 1'b0;
                if (tx_ready_o) begin
                    state_d    = S_LEAD;
                    word_d     = tx_data_i;
                    cpol_d     = cpol_i;
                    cpha_d     = cpha_i;
                    lsb_d      = lsb_i;
                    ass_d      = ass_i;
                    dtb_d      = dtb_i;
                    nss_l_d    = nss_i;
                    div_d      = div_i;
                    nss_d      = ~nss_i;
                    rx_shift_d = '0;
                    if (!cpha_i) mosi_d = tx_data_i[fpos[IW-1:0]];
                end
            end
            S_LEAD: begin
                cnt_d = cnt_next;
                sck_d = cpol_q;
                nss_d = ~nss_l_q;
                if (wrap) begin
                    state_d = S_XFER;
                    do_edge = 1'b1;
                end
            end
            S_XFER: begin
                cnt_d = cnt_next;
                if (wrap) begin
                    if (edge_q == two_n) state_d = S_TRAIL;
                    else                 do_edge = 1'b1;
                end
            end
            S_TRAIL: begin
                cnt_d = cnt_next;
                sck_d = cpol_q;
                if (wrap) begin
                    state_d    = S_GAP;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    nss_d      = ass_q ? '1 : ~nss_l_q;
                end
            end
            S_GAP: begin
                cnt_d = cnt_next;
                sck_d = cpol_q;
                if (wrap) begin
                    state_d = S_IDLE;
                    nss_d   = ass_i ? '1 : ~nss_i;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_edge) begin
            edge_d = e;
            sck_d  = ~sck_q;
            if (e[0]) begin
                if (!cpha_q) rx_shift_d[rx_pos[IW-1:0]] = spi_miso_i;
                else         mosi_d = word_q[tx_pos[IW-1:0]];
            end else begin
                if (cpha_q)           rx_shift_d[rx_pos[IW-1:0]] = spi_miso_i;
                else if (e != two_n)  mosi_d = word_q[tx_pos[IW-1:0]];
            end
        end

        // Disable aborts the frame outright; the popped word and partial RX data are dropped.
        if (state_q != S_IDLE && !en_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            edge_d     = '0;
            sck_d      = cpol_i;
            nss_d      = ass_i ? '1 : ~nss_i;
            mosi_d     = 1'b0;
            rx_valid_d = rx_valid_q & ~rx_ready_i;
            rx_data_d  = rx_data_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            word_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            ass_q      <= 1'b0;
            dtb_q      <= '0;
            nss_l_q    <= '0;
            div_q      <= '0;
            sck_q      <= 1'b0;
            nss_q      <= '1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            word_q     <= word_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            ass_q      <= ass_d;
            dtb_q      <= dtb_d;
            nss_l_q    <= nss_l_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            nss_q      <= nss_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign spi_sck_o  = sck_q;
    assign spi_nss_o  = nss_q;
    assign spi_mosi_o = mosi_q;
    assign busy_o     = busy_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: frames checked against a bit-list model of the
// serial protocol (bit order, edge count, half-period, NSS, busy length, RX word).
module tb_spi_shift_engine;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i, cpol_i, cpha_i, lsb_i, ass_i;
    logic [1:0]  dtb_i;
    logic [0:0]  nss_i;
    logic [15:0] div_i;
    logic        tx_valid_i;
    logic [31:0] tx_data_i;
    logic        tx_ready_o, rx_valid_o, rx_ready_i, busy_o;
    logic [31:0] rx_data_o;
    logic        spi_sck_o, spi_mosi_o, spi_miso_i;
    logic [0:0]  spi_nss_o;
    int          miso_mode;
    int          errors = 0;
    int          checks = 0;

    always #5 clk_i = ~clk_i;

    // 0: loopback MOSI->MISO, 1: tied high, 2: tied low
    assign spi_miso_i = (miso_mode == 0) ? spi_mosi_o : (miso_mode == 1);

    spi_shift_engine dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .lsb_i(lsb_i), .ass_i(ass_i), .dtb_i(dtb_i), .nss_i(nss_i), .div_i(div_i),
        .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .busy_o(busy_o), .spi_sck_o(spi_sck_o), .spi_nss_o(spi_nss_o),
        .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Runs one frame and checks it against a model built from the frame rules.
    task automatic run_frame(input logic cpol, input logic cpha, input logic lsb,
                             input logic ass, input logic [1:0] dtb, input int div,
                             input logic [31:0] word, input int mmode, input logic rxrdy);
        int n, busy_cnt, edges, cyc_since, half_bad, nss_bad, got;
        logic [31:0] mask, exp_rx, got_data;
        logic exp_q[$];
        logic prev_sck, exp_nss, b;
        n = 8 * (int'(dtb) + 1);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        for (int i = 0; i < n; i++) exp_q.push_back(lsb ? word[i] : word[n-1-i]);
        exp_rx = (mmode == 0) ? (word & mask) : (mmode == 1) ? mask : 32'd0;

        @(negedge clk_i);
        cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; ass_i = ass; dtb_i = dtb;
        div_i = div[15:0]; tx_data_i = word; tx_valid_i = 1'b0; rx_ready_i = rxrdy;
        miso_mode = mmode; en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (spi_sck_o !== cpol || spi_nss_o !== (ass ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL idle_lines: got sck=%b nss=%b expected sck=%b nss=%b",
                     spi_sck_o, spi_nss_o, cpol, ass);
        end
        tx_valid_i = 1'b1;
        #1;
        checks++;
        if (tx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept: got tx_ready=%b expected 1", tx_ready_o);
        end
        @(negedge clk_i);
        tx_valid_i = 1'b0;

        prev_sck = cpol; edges = 0; busy_cnt = 0; cyc_since = 0;
        half_bad = 0; nss_bad = 0; got = 0; got_data = '0;
        for (int c = 0; c < 20000; c++) begin
            if (busy_o !== 1'b1) break;
            busy_cnt++;
            exp_nss = ass && (busy_cnt > (2 * n + 2) * (div + 1));
            if (spi_nss_o !== exp_nss) nss_bad++;
            if (spi_sck_o !== prev_sck) begin
                edges++;
                if (edges > 1 && cyc_since != div + 1) half_bad++;
                cyc_since = 0;
                prev_sck = spi_sck_o;
                if ((edges % 2 == 1) != cpha) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mosi_extra: got sample edge %0d expected none", edges);
                    end else begin
                        b = exp_q.pop_front();
                        if (spi_mosi_o !== b) begin
                            errors++;
                            $display("FAIL mosi_bit: edge %0d got %b expected %b",
                                     edges, spi_mosi_o, b);
                        end
                    end
                end
            end
            cyc_since++;
            if (rx_valid_o === 1'b1 && got == 0) begin
                got = 1;
                got_data = rx_data_o;
            end
            @(negedge clk_i);
        end

        checks++;
        if (busy_cnt != (2 * n + 3) * (div + 1)) begin
            errors++;
            $display("FAIL busy_len: got %0d expected %0d", busy_cnt, (2 * n + 3) * (div + 1));
        end
        checks++;
        if (edges != 2 * n) begin
            errors++;
            $display("FAIL sck_edges: got %0d expected %0d", edges, 2 * n);
        end
        checks++;
        if (half_bad != 0) begin
            errors++;
            $display("FAIL sck_half: got %0d bad spacings expected 0 (div=%0d)", half_bad, div);
        end
        checks++;
        if (nss_bad != 0) begin
            errors++;
            $display("FAIL nss_frame: got %0d bad cycles expected 0", nss_bad);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mosi_count: got %0d bits unsent expected 0", exp_q.size());
        end
        checks++;
        if (got != 1 || got_data !== exp_rx) begin
            errors++;
            $display("FAIL rx_data: got valid=%0d data=%h expected 1 %h", got, got_data, exp_rx);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
        ass_i = 1'b1; dtb_i = 2'd0; nss_i = 1'b1; div_i = 16'd0; tx_valid_i = 1'b1;
        tx_data_i = 32'h55; rx_ready_i = 1'b1; miso_mode = 0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (spi_sck_o !== 1'b0 || spi_nss_o !== 1'b1 || spi_mosi_o !== 1'b0 ||
            busy_o !== 1'b0 || rx_valid_o !== 1'b0 || rx_data_o !== 32'd0 || tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: got sck=%b nss=%b mosi=%b busy=%b rxv=%b rxd=%h txr=%b expected 0 1 0 0 0 0 0",
                     spi_sck_o, spi_nss_o, spi_mosi_o, busy_o, rx_valid_o, rx_data_o, tx_ready_o);
        end
        tx_valid_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_mode0_a5();
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'h0000_00A5, 0, 1'b1);
    endtask

    task automatic test_mode3_lsb();
        run_frame(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1, 32'h1234_5678, 1, 1'b1);
    endtask

    task automatic test_mode1_div3();
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3, 32'($urandom_range(0, 65535)), 0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                      $urandom, $urandom_range(0, 2), 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w2;
        int bad, seen;
        w2 = $urandom;
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, $urandom, 0, 1'b0);
        tx_data_i = w2;
        tx_valid_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (tx_ready_o !== 1'b0 || busy_o !== 1'b0 || rx_valid_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rx_backpressure: got %0d bad cycles expected 0", bad);
        end
        rx_ready_i = 1'b1;
        #1;
        checks++;
        if (tx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL release_pop: got tx_ready=%b expected 1", tx_ready_o);
        end
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL release_start: got busy=%b rxv=%b expected 1 0", busy_o, rx_valid_o);
        end
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk_i);
            if (rx_valid_o === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 1 || rx_data_o !== {24'd0, w2[7:0]}) begin
            errors++;
            $display("FAIL second_word: got valid=%0d data=%h expected 1 %h", seen, rx_data_o, {24'd0, w2[7:0]});
        end
        while (busy_o === 1'b1) @(negedge clk_i);
    endtask

    task automatic test_abort();
        int edges, bad;
        logic prev;
        @(negedge clk_i);
        cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; ass_i = 1'b1; dtb_i = 2'd0;
        div_i = 16'd0; tx_data_i = 32'h3C; rx_ready_i = 1'b1; miso_mode = 0; en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        edges = 0; prev = 1'b0;
        for (int i = 0; i < 100 && edges < 5; i++) begin
            if (spi_sck_o !== prev) begin
                edges++;
                prev = spi_sck_o;
            end
            if (edges < 5) @(negedge clk_i);
        end
        en_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (spi_nss_o !== 1'b1 || busy_o !== 1'b0 || spi_sck_o !== 1'b0 || spi_mosi_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_lines: got nss=%b busy=%b sck=%b mosi=%b expected 1 0 0 0 (edges=%0d)",
                     spi_nss_o, busy_o, spi_sck_o, spi_mosi_o, edges);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (rx_valid_o !== 1'b0) bad++;
            @(negedge clk_i);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_rx: got %0d rx_valid cycles expected 0", bad);
        end
        en_i = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, $urandom, 0, 1'b1);
    endtask

    task automatic test_manual_nss();
        nss_i = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1, $urandom, 0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 0, $urandom, 0, 1'b1);
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        cpol_i = 1'b1; cpha_i = 1'b0; lsb_i = 1'b0; ass_i = 1'b0; dtb_i = 2'd3;
        div_i = 16'd2; tx_data_i = $urandom; rx_ready_i = 1'b1; miso_mode = 1; en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        repeat (20) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (spi_sck_o !== 1'b0 || spi_nss_o !== 1'b1 || spi_mosi_o !== 1'b0 ||
            busy_o !== 1'b0 || rx_valid_o !== 1'b0 || rx_data_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got sck=%b nss=%b mosi=%b busy=%b rxv=%b rxd=%h expected 0 1 0 0 0 0",
                     spi_sck_o, spi_nss_o, spi_mosi_o, busy_o, rx_valid_o, rx_data_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2, $urandom, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_mode0_a5();
        test_mode3_lsb();
        test_mode1_div3();
        test_random();
        test_back_to_back();
        test_abort();
        test_manual_nss();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
